// File: rtl/omsp_dsub_serial.sv
// Digit-serial BCD subtractor: result = A - B - borrow_in, one digit per cycle, LSD first.
// start is accepted in IDLE only; done pulses once when result and flags are valid.
module omsp_dsub_serial #(
  parameter int NDIG = 4
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              start,
  input  logic              byte_mode,
  input  logic [4*NDIG-1:0] op_a,
  input  logic [4*NDIG-1:0] op_b,
  input  logic              borrow_in,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              borrow_out,
  output logic              zero,
  output logic              inv
);

  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            br_q, br_d;
  logic            byte_q, byte_d;
  logic [W-1:0]    result_q, result_d;
  logic            borrow_out_q, borrow_out_d;
  logic            zero_q, zero_d;
  logic            inv_q, inv_d;
  logic            done_q, done_d;

  logic [3:0]      a_dig, b_dig;
  logic [4:0]      diff, adj;
  logic            neg, last;

  // Operands shift right each digit, so the active digit always sits in bits [3:0].
  assign a_dig = a_q[3:0];
  assign b_dig = b_q[3:0];
  assign diff  = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, br_q};
  assign neg   = diff[4];
  assign adj   = neg ? (diff + 5'd10) : diff;
  assign last  = byte_q ? (cnt_q == CW'(1)) : (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    br_d         = br_q;
    byte_d       = byte_q;
    result_d     = result_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    inv_d        = inv_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          cnt_d        = '0;
          a_d          = op_a;
          b_d          = op_b;
          br_d         = borrow_in;
          byte_d       = byte_mode;
          result_d     = '0;
          borrow_out_d = 1'b0;
          zero_d       = 1'b0;
          inv_d        = 1'b0;
        end
      end
      S_RUN: begin
        result_d[{cnt_q, 2'b00} +: 4] = adj[3:0];
        a_d  = a_q >> 4;
        b_d  = b_q >> 4;
        br_d = neg;
        if ((a_dig > 4'd9) || (b_dig > 4'd9)) inv_d = 1'b1;
        if (last) begin
          state_d      = S_DONE;
          borrow_out_d = neg;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        // Inactive upper digits were cleared at start, so the full width compare is exact.
        zero_d  = (result_q == '0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      br_q         <= 1'b0;
      byte_q       <= 1'b0;
      result_q     <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      inv_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      br_q         <= br_d;
      byte_q       <= byte_d;
      result_q     <= result_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      inv_q        <= inv_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign result     = result_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;
  assign inv        = inv_q;

endmodule

// File: tb/tb_omsp_dsub_serial.sv
// Directed bench for omsp_dsub_serial: hand-computed BCD differences, latency and handshake checks.
module tb_omsp_dsub_serial;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_mode = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        borrow_in = 1'b0;
  logic        busy, done, borrow_out, zero, inv;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;
  int lat;
  int done_cnt;

  omsp_dsub_serial #(.NDIG(4)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .byte_mode(byte_mode),
    .op_a(op_a), .op_b(op_b), .borrow_in(borrow_in), .busy(busy), .done(done),
    .result(result), .borrow_out(borrow_out), .zero(zero), .inv(inv)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pulse start for one edge, then wait (bounded) for done; lat = edges after the start edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin, input logic bm);
    op_a = a; op_b = b; borrow_in = bin; byte_mode = bm; start = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge mclk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    $display("[TB] op a=%h b=%h bin=%0d byte=%0d -> result=%h bout=%0d zero=%0d inv=%0d lat=%0d",
             a, b, bin, bm, result, borrow_out, zero, inv, lat);
  endtask

  initial begin
    repeat (2) @(posedge mclk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags", {29'd0, borrow_out, zero, inv}, 32'd0);
    puc_rst = 1'b0;
    @(posedge mclk); #1;

    // 1: word 0042 - 0017
    run_op(16'h0042, 16'h0017, 1'b0, 1'b0);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_result", 32'(result), 32'h0025);
    check("t1_bout", 32'(borrow_out), 32'd0);
    check("t1_zero", 32'(zero), 32'd0);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    @(posedge mclk); #1;
    check("t1_done_pulse", 32'(done), 32'd0);
    repeat (3) @(posedge mclk); #1;
    check("t1_result_held", 32'(result), 32'h0025);

    // 2: word 0000 - 0001
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    check("t2_result", 32'(result), 32'h9999);
    check("t2_bout", 32'(borrow_out), 32'd1);
    check("t2_zero", 32'(zero), 32'd0);

    // 3: byte 1250 - 3450, upper digits ignored
    run_op(16'h1250, 16'h3450, 1'b0, 1'b1);
    check("t3_latency", 32'(lat), 32'd3);
    check("t3_result", 32'(result), 32'h0000);
    check("t3_zero", 32'(zero), 32'd1);
    check("t3_bout", 32'(borrow_out), 32'd0);

    // 4: word 1000 - 0000 with borrow in
    run_op(16'h1000, 16'h0000, 1'b1, 1'b0);
    check("t4_result", 32'(result), 32'h0999);
    check("t4_bout", 32'(borrow_out), 32'd0);

    // byte with borrow out: 05 - 17 = 88 borrow 1
    run_op(16'h0005, 16'h0017, 1'b0, 1'b1);
    check("tb_result", 32'(result), 32'h0088);
    check("tb_bout", 32'(borrow_out), 32'd1);

    // 5: invalid digit, then inv clears on the next op
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
    check("t5_result", 32'(result), 32'h00A0);
    check("t5_inv", 32'(inv), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    check("t5b_inv", 32'(inv), 32'd0);
    check("t5b_zero", 32'(zero), 32'd1);

    // 6a: start re-pulsed during RUN is ignored
    op_a = 16'h0042; op_b = 16'h0017; borrow_in = 1'b0; byte_mode = 1'b0; start = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    check("t6_busy", 32'(busy), 32'd1);
    @(posedge mclk); #1;
    op_a = 16'h9999; op_b = 16'h1111; start = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) done_cnt++;
      @(posedge mclk); #1;
    end
    check("t6_done_count", 32'(done_cnt), 32'd1);
    check("t6_result", 32'(result), 32'h0025);

    // 6b: reset mid-operation abandons the op
    op_a = 16'h5555; op_b = 16'h1111; start = 1'b1;
    @(posedge mclk); #1;
    start = 1'b0;
    @(posedge mclk); #1;
    puc_rst = 1'b1;
    @(posedge mclk); #1;
    puc_rst = 1'b0;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_result", 32'(result), 32'h0);
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge mclk); #1;
      if (done) done_cnt++;
    end
    check("t6_rst_no_done", 32'(done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
